// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Purpose  : Shared constants and state encoding for the coin vendor with
//             change return: denomination values, coin bit indices and the
//             vendor FSM state type.
//  Revision : 1.0  initial release
// ============================================================================
package vend_pkg;

  // Number of accepted denominations (one bit each on coin buses)
  localparam int unsigned c_NUM_DEN = 4;

  // Bit positions on coin_in / coin_out / coin_reject buses
  localparam int unsigned c_IDX_1  = 0;
  localparam int unsigned c_IDX_2  = 1;
  localparam int unsigned c_IDX_5  = 2;
  localparam int unsigned c_IDX_10 = 3;

  // Face value of each denomination, indexed by bit position
  localparam int unsigned c_DEN_VAL [c_NUM_DEN] = '{1, 2, 5, 10};

  // Vendor FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// ============================================================================
//  Module   : coin_inventory
//  Purpose  : Stock counter for one coin denomination. Counts up when a coin
//             of this value is accepted and down when one is paid out; it
//             saturates at both ends instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module coin_inventory #(
  parameter int CNT_W      = 4,
  parameter int INIT_COINS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nonzero
);

  localparam logic [CNT_W-1:0] c_MAX  = '1;
  localparam logic [CNT_W-1:0] c_INIT = CNT_W'(INIT_COINS);

  logic [CNT_W-1:0] r_cnt;

  // Saturating up/down count; a full hopper still takes coins but stops counting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= c_INIT;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   if (r_cnt != c_MAX)     r_cnt <= r_cnt + 1'b1;
        2'b01:   if (r_cnt != '0)        r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt     = r_cnt;
  assign o_nonzero = (r_cnt != '0);

endmodule : coin_inventory
`default_nettype wire

// File: rtl/coin_vendor_change.sv
`default_nettype none
// ============================================================================
//  Module   : coin_vendor_change
//  Purpose  : Parametrised coin vendor. Accepts 1/2/5/10 coins, releases the
//             item once credit reaches PRICE, then returns change greedily,
//             one coin per cycle, from a per-denomination inventory. Supports
//             cancel/refund and reports change it could not pay out.
//  Revision : 1.0  initial release
// ============================================================================
module coin_vendor_change
  import vend_pkg::*;
#(
  parameter int PRICE      = 13,
  parameter int CREDIT_W   = 6,
  parameter int CNT_W      = 4,
  parameter int INIT_COINS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           i_coin_in,
  input  logic                 i_cancel,
  output logic [CREDIT_W-1:0]  o_credit,
  output logic                 o_vended,
  output logic                 o_busy,
  output logic [3:0]           o_coin_out,
  output logic [3:0]           o_coin_reject,
  output logic                 o_short_change,
  output logic [CREDIT_W-1:0]  o_owed,
  output logic [4*CNT_W-1:0]   o_inv_cnt
);

  localparam logic [CREDIT_W-1:0] c_PRICE = CREDIT_W'(PRICE);

  state_t                r_state;
  state_t                w_next_state;
  logic [CREDIT_W-1:0]   r_credit;
  logic [CREDIT_W-1:0]   r_remaining;
  logic [CREDIT_W-1:0]   r_owed;
  logic                  r_short;

  logic [c_NUM_DEN-1:0]  w_coin_sel;
  logic [CREDIT_W-1:0]   w_coin_val;
  logic [c_NUM_DEN-1:0]  w_pay_sel;
  logic [CREDIT_W-1:0]   w_pay_val;
  logic [c_NUM_DEN-1:0]  w_inc;
  logic [c_NUM_DEN-1:0]  w_nz;
  logic [CNT_W-1:0]      w_cnt [c_NUM_DEN];

  logic                  w_credit_full;
  logic                  w_collecting;
  logic                  w_accept;
  logic                  w_cancel_take;
  logic                  w_can_pay;

  // Once credit covers the price the next edge vends; coins arriving in that
  // cycle are bounced, which keeps credit below PRICE+10.
  assign w_credit_full = (r_credit >= c_PRICE);
  assign w_collecting  = (r_state == ST_IDLE) ||
                         ((r_state == ST_COLLECT) && !w_credit_full);
  assign w_accept      = w_collecting && (i_coin_in != 4'b0000) && !i_cancel;
  assign w_cancel_take = (r_state == ST_COLLECT) && !w_credit_full && i_cancel;
  assign w_inc         = w_accept ? w_coin_sel : '0;
  assign w_can_pay     = (w_pay_sel != '0);

  // Highest set coin bit wins when the front end reports several at once
  always_comb begin
    w_coin_sel = '0;
    w_coin_val = '0;
    for (int i = 0; i < c_NUM_DEN; i++) begin
      if (i_coin_in[i]) begin
        w_coin_sel    = '0;
        w_coin_sel[i] = 1'b1;
        w_coin_val    = CREDIT_W'(c_DEN_VAL[i]);
      end
    end
  end

  // Greedy change: largest stocked denomination not exceeding what is owed
  always_comb begin
    w_pay_sel = '0;
    w_pay_val = '0;
    for (int i = 0; i < c_NUM_DEN; i++) begin
      if (w_nz[i] && (CREDIT_W'(c_DEN_VAL[i]) <= r_remaining)) begin
        w_pay_sel    = '0;
        w_pay_sel[i] = 1'b1;
        w_pay_val    = CREDIT_W'(c_DEN_VAL[i]);
      end
    end
  end

  // One stock counter per denomination
  for (genvar g = 0; g < c_NUM_DEN; g++) begin : g_inv
    coin_inventory #(
      .CNT_W      (CNT_W),
      .INIT_COINS (INIT_COINS)
    ) u_inv (
      .clk       (clk),
      .reset     (reset),
      .i_inc     (w_inc[g]),
      .i_dec     (o_coin_out[g]),
      .o_cnt     (w_cnt[g]),
      .o_nonzero (w_nz[g])
    );
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_COLLECT;
      ST_COLLECT: begin
        if (w_credit_full)      w_next_state = ST_VEND;
        else if (w_cancel_take) w_next_state = ST_CHANGE;
      end
      ST_VEND:    w_next_state = ST_CHANGE;
      ST_CHANGE:  if ((r_remaining == '0) || !w_can_pay) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: vend/busy by state, change coin while something is owed, bounce unaccepted coins
  always_comb begin
    o_vended      = 1'b0;
    o_busy        = 1'b0;
    o_coin_out    = 4'b0000;
    o_coin_reject = i_coin_in & ~w_inc;
    case (r_state)
      ST_VEND: begin
        o_vended = 1'b1;
        o_busy   = 1'b1;
      end
      ST_CHANGE: begin
        o_busy = 1'b1;
        if (r_remaining != '0) o_coin_out = w_pay_sel;
      end
      default: ;
    endcase
  end

  // Credit, change-owed and short-change bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credit    <= '0;
      r_remaining <= '0;
      r_owed      <= '0;
      r_short     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_credit <= r_credit + w_coin_val;
            r_short  <= 1'b0;
            r_owed   <= '0;
          end
        end
        ST_COLLECT: begin
          if (w_credit_full) begin
            r_remaining <= r_credit - c_PRICE;
            r_credit    <= '0;
          end else if (w_cancel_take) begin
            r_remaining <= r_credit;
            r_credit    <= '0;
          end else if (w_accept) begin
            r_credit <= r_credit + w_coin_val;
          end
        end
        ST_CHANGE: begin
          if (r_remaining != '0) begin
            if (w_can_pay) begin
              r_remaining <= r_remaining - w_pay_val;
            end else begin
              r_short     <= 1'b1;
              r_owed      <= r_remaining;
              r_remaining <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_credit       = r_credit;
  assign o_short_change = r_short;
  assign o_owed         = r_owed;
  assign o_inv_cnt      = {w_cnt[c_IDX_10], w_cnt[c_IDX_5], w_cnt[c_IDX_2], w_cnt[c_IDX_1]};

endmodule : coin_vendor_change
`default_nettype wire

// File: tb/tb_coin_vendor_change.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coin_vendor_change
//  Purpose  : Directed scoreboard bench for coin_vendor_change. Instance A uses
//             default stock; instance B starts with empty inventories.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coin_vendor_change;

  localparam int CW = 6;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [3:0]    a_coin = '0, b_coin = '0;
  logic          a_cancel = 1'b0, b_cancel = 1'b0;
  logic [CW-1:0] a_credit, b_credit, a_owed, b_owed;
  logic          a_vended, b_vended, a_busy, b_busy, a_short, b_short;
  logic [3:0]    a_cout, b_cout, a_rej, b_rej;
  logic [4*NW-1:0] a_inv, b_inv;

  coin_vendor_change #(.PRICE(13), .CREDIT_W(CW), .CNT_W(NW), .INIT_COINS(4)) dut_a (
    .clk(clk), .reset(reset), .i_coin_in(a_coin), .i_cancel(a_cancel),
    .o_credit(a_credit), .o_vended(a_vended), .o_busy(a_busy), .o_coin_out(a_cout),
    .o_coin_reject(a_rej), .o_short_change(a_short), .o_owed(a_owed), .o_inv_cnt(a_inv)
  );

  coin_vendor_change #(.PRICE(13), .CREDIT_W(CW), .CNT_W(NW), .INIT_COINS(0)) dut_b (
    .clk(clk), .reset(reset), .i_coin_in(b_coin), .i_cancel(b_cancel),
    .o_credit(b_credit), .o_vended(b_vended), .o_busy(b_busy), .o_coin_out(b_cout),
    .o_coin_reject(b_rej), .o_short_change(b_short), .o_owed(b_owed), .o_inv_cnt(b_inv)
  );

  always #5 clk = ~clk;

  // Expected output events: kind 0 = vend, 1 = coin out (val = one-hot), 2 = short (val = owed)
  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  logic b_short_q = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input bit which, input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    if (which) qb.push_back(e);
    else       qa.push_back(e);
  endtask

  task automatic pop_cmp(input bit which, input int kind, input int val);
    ev_t e;
    total++;
    if ((!which && qa.size() == 0) || (which && qb.size() == 0)) begin
      bad++;
      $display("FAIL dut%0d unexpected event: got kind=%0d val=%0d expected none", which, kind, val);
    end else begin
      e = which ? qb.pop_front() : qa.pop_front();
      if (e.kind != kind || e.val != val) begin
        bad++;
        $display("FAIL dut%0d event: got kind=%0d val=%0d expected kind=%0d val=%0d",
                 which, kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor: pop and compare whenever either DUT presents a pulse
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_vended)          pop_cmp(1'b0, 0, 0);
      if (a_cout != 4'b0000) pop_cmp(1'b0, 1, int'(a_cout));
      if (b_vended)          pop_cmp(1'b1, 0, 0);
      if (b_cout != 4'b0000) pop_cmp(1'b1, 1, int'(b_cout));
      if (b_short && !b_short_q) pop_cmp(1'b1, 2, int'(b_owed));
    end
    b_short_q <= b_short;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0] c);
    a_coin = c;
    tick();
    a_coin = '0;
  endtask

  task automatic send_b(input logic [3:0] c);
    b_coin = c;
    tick();
    b_coin = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Count busy cycles of instance A until it returns to idle (bounded)
  task automatic wait_idle_a(output int n);
    bit seen;
    n    = 0;
    seen = a_busy;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (a_busy) begin
        n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("idle_reached", int'(a_busy), 0);
  endtask

  initial begin
    int n;
    tick();
    tick();
    // Reset state (reset still asserted)
    check("rst_credit", int'(a_credit), 0);
    check("rst_pulses", int'({a_vended, a_busy, a_cout, a_rej}), 0);
    check("rst_short_owed", int'({a_short, a_owed}), 0);
    check("rst_inv_a", int'(a_inv), 16'h4444);
    check("rst_inv_b", int'(b_inv), 16'h0000);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Exact pay 10+2+1
    expect_ev(1'b0, 0, 0);
    send_a(4'b1000);
    send_a(4'b0010);
    check("credit_12", int'(a_credit), 12);
    send_a(4'b0001);
    check("credit_13", int'(a_credit), 13);
    wait_idle_a(n);
    check("exact_busy", n, 2);
    check("exact_inv", int'(a_inv), 16'h5455);
    check("exact_credit", int'(a_credit), 0);

    // 10+10: change 7 = 5 then 2
    do_reset();
    expect_ev(1'b0, 0, 0);
    expect_ev(1'b0, 1, 4'b0100);
    expect_ev(1'b0, 1, 4'b0010);
    send_a(4'b1000);
    send_a(4'b1000);
    wait_idle_a(n);
    check("change_busy", n, 4);
    check("change_inv", int'(a_inv), 16'h6334);

    // Pay 5 then cancel; a coin offered during refund bounces
    do_reset();
    expect_ev(1'b0, 1, 4'b0100);
    send_a(4'b0100);
    a_cancel = 1'b1;
    tick();
    a_cancel = 1'b0;
    a_coin = 4'b1000;
    #1;
    check("reject_in_change", int'(a_rej), 4'b1000);
    check("busy_in_change", int'(a_busy), 1);
    tick();
    a_coin = '0;
    wait_idle_a(n);
    check("cancel_credit", int'(a_credit), 0);
    check("cancel_inv", int'(a_inv), 16'h4444);

    // Multi-bit coin in IDLE: highest bit accepted
    do_reset();
    a_coin = 4'b0101;
    #1;
    check("multibit_reject", int'(a_rej), 4'b0001);
    tick();
    a_coin = '0;
    check("multibit_credit", int'(a_credit), 5);
    check("multibit_inv", int'(a_inv), 16'h4544);

    // Thirteen 1-coins: cnt1 saturates at 15
    do_reset();
    expect_ev(1'b0, 0, 0);
    repeat (13) send_a(4'b0001);
    wait_idle_a(n);
    check("sat_busy", n, 2);
    check("sat_inv", int'(a_inv), 16'h444F);

    // Empty 1/2 stock: pay 10+5, owed 2 cannot be paid
    do_reset();
    expect_ev(1'b1, 0, 0);
    expect_ev(1'b1, 2, 2);
    send_b(4'b1000);
    send_b(4'b0100);
    repeat (4) tick();
    check("short_flag", int'(b_short), 1);
    check("short_owed", int'(b_owed), 2);
    check("short_inv", int'(b_inv), 16'h1100);
    check("short_busy", int'(b_busy), 0);
    send_b(4'b0001);
    check("short_clear", int'({b_short, b_owed}), 0);
    check("short_credit", int'(b_credit), 1);

    // Reset during change: pending change discarded
    do_reset();
    expect_ev(1'b0, 0, 0);
    expect_ev(1'b0, 1, 4'b0100);
    send_a(4'b1000);
    send_a(4'b1000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_pulses", int'({a_vended, a_busy, a_cout}), 0);
    check("midrst_regs", int'({a_credit, a_short, a_owed}), 0);
    check("midrst_inv", int'(a_inv), 16'h4444);
    reset = 1'b0;
    repeat (5) tick();

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_coin_vendor_change
`default_nettype wire
